dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter sharing the single-port data memory (DMEM) between the pipelined CPU's data port and a debug/loader port. It muxes address, write data and byte enables onto the memory and routes the synchronous read data back to the owner. The CPU has fixed priority, with an optional starvation guard so a debug requester is never locked out. It sits between the core's MemWrite/MemWriteSelect/DataAdr/WriteData/ReadData interface and the DMEM array.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_LIMIT, 8, consecutive denied debug cycles before a forced debug grant (≥1)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (0 = in reset)
- cpu_req / dbg_req  in  1  access request
- cpu_we / dbg_we  in  1  1 = write, 0 = read
- cpu_be / dbg_be  in  DATA_W/8  byte enables (writes only)
- cpu_addr / dbg_addr  in  ADDR_W  byte address
- cpu_wdata / dbg_wdata  in  DATA_W  write data
- cpu_gnt / dbg_gnt  out  1  request accepted this cycle (combinational)
- cpu_rvalid / dbg_rvalid  out  1  read data valid (registered)
- cpu_rdata / dbg_rdata  out  DATA_W  read data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_be  out  DATA_W/8  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read enable

## Operation
- Exactly one access per cycle. A transfer occurs on req && gnt; requester fields are sampled in that cycle.
- Grant rules with force = 0: cpu_gnt = cpu_req; dbg_gnt = dbg_req && !cpu_req.
- Grant rules with force = 1: dbg_gnt = dbg_req; cpu_gnt = cpu_req && !dbg_req. The CPU must hold its request until granted.
- While reset = 0, both grants and mem_en are forced to 0.
- Memory mux: mem_en = cpu_gnt | dbg_gnt. mem_we, mem_be, mem_addr and mem_wdata come from the granted side.
- mem_be is all-zero on reads. With no grant, mem_we = 0 and the other memory outputs are 0.
- Read return uses registers rd_pend (1 b) and rd_owner (0 = CPU, 1 = debug).
  - On a granted read, rd_pend is set to 1 and rd_owner records the winner.
  - Otherwise rd_pend is cleared to 0.
  - {x}_rvalid = rd_pend && owner match.
  - {x}_rdata = mem_rdata when {x}_rvalid, else 0.
- Writes produce no rvalid.
- Starvation counter starve_cnt has width clog2(STARVE_LIMIT+1).
  - Cleared to 0 when dbg_gnt or !dbg_req.
  - Incremented when dbg_req && !dbg_gnt.
  - Saturates at STARVE_LIMIT.
  - force = (starve_cnt == STARVE_LIMIT).
  - A forced debug grant clears starve_cnt, which returns control to CPU priority on the next cycle.
- Arbiter states:
  - CPU_PRI (force = 0) → DBG_FORCE when starve_cnt reaches STARVE_LIMIT.
  - DBG_FORCE → CPU_PRI after any dbg_gnt, or when dbg_req drops.

## Timing
- Grant: 0-cycle (combinational from req and state).
- Read latency: rvalid is asserted exactly 1 cycle after the granted read.
- Back-to-back reads: one return per cycle, in issue order. Owner may alternate cycle to cycle.
- Reset values: rd_pend = 0, rd_owner = 0, starve_cnt = 0, all rvalid = 0, all rdata = 0, mem_en = 0.
- Reset asserted mid-operation discards the pending return. No rvalid appears after reset is released.
- Simultaneous requests: only the winner's address appears on mem_addr. The loser's fields are ignored that cycle, including same-address conflicts.
- Debug request dropped while waiting clears starve_cnt. It is not an error.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined: starvation counter and DBG_FORCE state are implemented as above.
- DMEM_ARB_STARVE_GUARD_EN undefined: force is tied to 0 and there is no counter logic. The arbiter is strict CPU priority, and dbg_gnt = dbg_req && !cpu_req always.

## Test plan
- CPU read only: cpu_req = 1, we = 0, addr 0x10, with mem holding 0xDEADBEEF. Expect cpu_gnt same cycle, cpu_rvalid next cycle with cpu_rdata = 0xDEADBEEF, and dbg_rvalid = 0.
- Debug byte write: dbg write be = 4'b0010, addr 0x20, wdata 0x0000AB00, with cpu_req = 0. Expect mem_en = 1, mem_we = 1, mem_be = 0010, mem_addr = 0x20, and no rvalid.
- Starvation guard (macro defined, STARVE_LIMIT = 8): cpu_req and dbg_req held at 1. Expect dbg_gnt = 0 for 8 cycles, dbg_gnt = 1 with cpu_gnt = 0 on the 9th, then the pattern repeats.
- Same stimulus with the macro undefined: expect dbg_gnt = 0 for 100 cycles.
- Interleaved reads: CPU read 0x4 at cycle n, debug read 0x8 at cycle n+1 (cpu_req = 0). Expect cpu_rvalid at n+1 with mem[0x4] and dbg_rvalid at n+2 with mem[0x8].
- Reset mid-read: grant a CPU read, then pull reset low the next cycle. Expect cpu_rvalid = 0, mem_en = 0, starve_cnt = 0, and no rvalid pulse after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester DMEM arbiter: CPU data port has priority over the debug/loader port.
// Define DMEM_ARB_STARVE_GUARD_EN to add the debug starvation guard (DBG_FORCE state).
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [DATA_W/8-1:0] cpu_be,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [DATA_W/8-1:0] dbg_be,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  if (STARVE_LIMIT < 1) begin : gBadLimit
    $error("dmem_arbiter: STARVE_LIMIT must be at least 1");
  end

  logic cpuGnt;
  logic dbgGnt;
  logic forceDbg;
  logic rdPend;
  logic rdOwner;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {CPU_PRI, DBG_FORCE} arbState_t;

  arbState_t        state;
  arbState_t        stateNext;
  logic [CNT_W-1:0] starveCnt;
  logic [CNT_W-1:0] starveCntNext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CPU_PRI;
      starveCnt <= '0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveCntNext;
    end
  end

  // DBG_FORCE is entered exactly when the counter saturates, so it mirrors starveCnt == STARVE_LIMIT.
  always_comb begin
    starveCntNext = starveCnt;
    stateNext     = state;
    if (dbgGnt || !dbg_req)
      starveCntNext = '0;
    else if (starveCnt != CNT_W'(STARVE_LIMIT))
      starveCntNext = starveCnt + 1'b1;
    case (state)
      CPU_PRI:   if (starveCntNext == CNT_W'(STARVE_LIMIT)) stateNext = DBG_FORCE;
      DBG_FORCE: if (dbgGnt || !dbg_req) stateNext = CPU_PRI;
      default:   stateNext = CPU_PRI;
    endcase
  end

  assign forceDbg = (state == DBG_FORCE);
`else
  assign forceDbg = 1'b0;
`endif

  always_comb begin
    cpuGnt = 1'b0;
    dbgGnt = 1'b0;
    if (reset) begin
      if (forceDbg) begin
        dbgGnt = dbg_req;
        cpuGnt = cpu_req && !dbg_req;
      end else begin
        cpuGnt = cpu_req;
        dbgGnt = dbg_req && !cpu_req;
      end
    end
  end

  // Only the winner's fields reach the memory; byte enables are meaningless on reads.
  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpuGnt) begin
      mem_we    = cpu_we;
      mem_be    = cpu_we ? cpu_be : {BE_W{1'b0}};
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbgGnt) begin
      mem_we    = dbg_we;
      mem_be    = dbg_we ? dbg_be : {BE_W{1'b0}};
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign mem_en  = cpuGnt | dbgGnt;
  assign cpu_gnt = cpuGnt;
  assign dbg_gnt = dbgGnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPend  <= 1'b0;
      rdOwner <= 1'b0;
    end else begin
      rdPend <= mem_en && !mem_we;
      if (mem_en && !mem_we)
        rdOwner <= dbgGnt;
    end
  end

  assign cpu_rvalid = rdPend && !rdOwner;
  assign dbg_rvalid = rdPend && rdOwner;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a 64-word DMEM stand-in plus a transaction-level reference model.
// Builds with or without DMEM_ARB_STARVE_GUARD_EN; the model follows the same macro.
module tb_dmem_arbiter;

  localparam int LIMIT = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [3:0]  cpu_be, dbg_be;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] memRdata;

  logic [31:0] envMem [64];
  logic [31:0] refMem [64];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          waitCnt = 0;
  bit          expPend = 1'b0;
  bit          expOwner = 1'b0;
  logic [31:0] expData = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(rstN),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(memRdata)
  );

  // Synchronous single-port memory; returns junk whenever no read was issued.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) envMem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      memRdata <= $urandom;
    end else if (mem_en) begin
      memRdata <= envMem[mem_addr[7:2]];
    end else begin
      memRdata <= $urandom;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Drives one cycle of requests, checks every output against the model, then advances a clock.
  task automatic step(input logic cr, input logic cw, input logic [3:0] cb, input logic [31:0] ca,
                      input logic [31:0] cd, input logic dr, input logic dw, input logic [3:0] db,
                      input logic [31:0] da, input logic [31:0] dd);
    logic eCG, eDG, eEn, eWe;
    logic [3:0]  eBe;
    logic [31:0] eAddr, eWd;
    bit forced;
    cpu_req = cr; cpu_we = cw; cpu_be = cb; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_be = db; dbg_addr = da; dbg_wdata = dd;
    #2;
    if (!rstN) begin
      expPend = 1'b0;
      waitCnt = 0;
    end
    forced = GUARD && (waitCnt == LIMIT);
    eCG = 1'b0;
    eDG = 1'b0;
    if (rstN) begin
      eDG = forced ? dr : (dr && !cr);
      eCG = cr && !eDG;
    end
    eEn = eCG || eDG;
    eWe = 1'b0; eBe = '0; eAddr = '0; eWd = '0;
    if (eCG) begin
      eWe = cw; eBe = cw ? cb : 4'h0; eAddr = ca; eWd = cd;
    end else if (eDG) begin
      eWe = dw; eBe = dw ? db : 4'h0; eAddr = da; eWd = dd;
    end
    checkVal("cpu_gnt", 32'(cpu_gnt), 32'(eCG));
    checkVal("dbg_gnt", 32'(dbg_gnt), 32'(eDG));
    checkVal("mem_en", 32'(mem_en), 32'(eEn));
    checkVal("mem_we", 32'(mem_we), 32'(eWe));
    checkVal("mem_be", 32'(mem_be), 32'(eBe));
    checkVal("mem_addr", mem_addr, eAddr);
    checkVal("mem_wdata", mem_wdata, eWd);
    checkVal("cpu_rvalid", 32'(cpu_rvalid), 32'(expPend && !expOwner));
    checkVal("dbg_rvalid", 32'(dbg_rvalid), 32'(expPend && expOwner));
    checkVal("cpu_rdata", cpu_rdata, (expPend && !expOwner) ? expData : 32'h0);
    checkVal("dbg_rdata", dbg_rdata, (expPend && expOwner) ? expData : 32'h0);
    if (eEn)
      $display("cyc %0d %s %s addr=%h be=%b wdata=%h wait=%0d", cyc, eCG ? "cpu" : "dbg",
               eWe ? "wr" : "rd", eAddr, eBe, eWd, waitCnt);
    expPend = eEn && !eWe;
    if (expPend) begin
      expOwner = eDG;
      expData  = refMem[eAddr[7:2]];
    end
    if (eEn && eWe)
      for (int b = 0; b < 4; b++)
        if (eBe[b]) refMem[eAddr[7:2]][8*b +: 8] = eWd[8*b +: 8];
    if (!rstN || eDG || !dr) waitCnt = 0;
    else if (waitCnt < LIMIT) waitCnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rstN = 1'b0;
    @(posedge clk);
    #1;
    idle();
    idle();
    rstN = 1'b1;
    // Load every word through the debug port so both memories start identical.
    for (int i = 0; i < 64; i++)
      step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom);

    // CPU read of a known word
    step(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();
    // Debug byte write
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000AB00);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    idle();
    // Both requesting continuously: starvation pattern
    for (int i = 0; i < 30; i++)
      step(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    idle();
    // Interleaved reads
    step(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    idle();
    // Reset during a pending CPU read, with both requesters still asking
    step(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    rstN = 1'b0;
    step(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    rstN = 1'b1;
    idle();
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);

    // Random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      rstN = ($urandom_range(0, 49) != 0);
      step($urandom_range(0, 99) < 60, 1'($urandom), 4'($urandom), 32'($urandom_range(0, 255)),
           $urandom, $urandom_range(0, 99) < 50, 1'($urandom), 4'($urandom),
           32'($urandom_range(0, 255)), $urandom);
    end
    rstN = 1'b1;
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
